apb_wb_bridge: RTL and testbench

- Parametrised APB-to-Wishbone slave bridge; next generation of the APB wrapper used in front of Wishbone peripheral cores (CAN, etc.).
- Registers the APB setup phase and runs a full Wishbone classic cycle.
- Inserts APB wait states (PREADY) until the core acks or errors, and returns PSLVERR on bus error or timeout.
- Synchronises the core interrupt to CLK before it reaches the interrupt controller.

---
 rtl/apb_wb_bridge.sv | 148 ++++++++++++++
 tb/tb_apb_wb_bridge.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_wb_bridge.sv
// APB slave to Wishbone classic master bridge with an interrupt synchroniser.
// Optional macro WB_TIMEOUT_EN aborts a Wishbone cycle after TIMEOUT cycles without ack/err.
module apb_wb_bridge #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          PSEL,
  input  logic          PENABLE,
  input  logic          PWRITE,
  input  logic [31:0]   PADDR,
  input  logic [DW-1:0] PWDATA,
  output logic [DW-1:0] PRDATA,
  output logic          PREADY,
  output logic          PSLVERR,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          irq_i,
  output logic          INT
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t        state, state_n;
  logic          cyc, cyc_n;
  logic          we, we_n;
  logic [AW-1:0] adr, adr_n;
  logic [DW-1:0] wdat, wdat_n;
  logic [DW-1:0] rdat, rdat_n;
  logic          slverr, slverr_n;
  logic          ready, ready_n;
  logic          timeout_hit;
  logic          irq_p0, irq_p1;
  logic          unused_addr;

  assign unused_addr = ^PADDR[31:AW];

`ifdef WB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  // Counter runs only while in BUS, so it is zero on every entry to BUS.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)              cnt <= '0;
    else if (state != BUS)  cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

  assign timeout_hit = (state == BUS) && (cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      cyc    <= 1'b0;
      we     <= 1'b0;
      adr    <= '0;
      wdat   <= '0;
      rdat   <= '0;
      slverr <= 1'b0;
      ready  <= 1'b0;
    end else begin
      state  <= state_n;
      cyc    <= cyc_n;
      we     <= we_n;
      adr    <= adr_n;
      wdat   <= wdat_n;
      rdat   <= rdat_n;
      slverr <= slverr_n;
      ready  <= ready_n;
    end
  end

  always_comb begin
    state_n  = state;
    cyc_n    = cyc;
    we_n     = we;
    adr_n    = adr;
    wdat_n   = wdat;
    rdat_n   = rdat;
    slverr_n = slverr;
    ready_n  = 1'b0;
    case (state)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          we_n    = PWRITE;
          adr_n   = PADDR[AW-1:0];
          wdat_n  = PWDATA;
          cyc_n   = 1'b1;
          state_n = BUS;
        end
      end
      BUS: begin
        if (wb_ack_i || wb_err_i || timeout_hit) begin
          cyc_n = 1'b0;
          // A master that dropped PSEL mid-transfer gets no response phase.
          if (PSEL) begin
            state_n  = RESP;
            ready_n  = 1'b1;
            slverr_n = wb_err_i || !wb_ack_i;
            rdat_n   = (wb_err_i || !wb_ack_i || we) ? '0 : wb_dat_i;
          end else begin
            state_n = IDLE;
          end
        end
      end
      RESP: begin
        state_n  = IDLE;
        rdat_n   = '0;
        slverr_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      irq_p0 <= 1'b0;
      irq_p1 <= 1'b0;
    end else begin
      irq_p0 <= irq_i;
      irq_p1 <= irq_p0;
    end
  end

  assign PRDATA   = rdat;
  assign PREADY   = ready;
  assign PSLVERR  = slverr;
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = we;
  assign wb_adr_o = adr;
  assign wb_dat_o = wdat;
  assign INT      = irq_p1;

endmodule

// File: tb/tb_apb_wb_bridge.sv
// Self-checking bench for apb_wb_bridge: vector table, hand-written corner sequences, random transfers.
module tb_apb_wb_bridge;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic          wb_ack_i, wb_err_i;
  logic          irq_i, INT;

  int tests = 0;
  int fails = 0;

  apb_wb_bridge #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .irq_i(irq_i), .INT(INT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    bit          err;
    bit          ack;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference: a read returns the slave data unless the cycle errored; writes always return zero.
  function automatic logic [31:0] model_rdata(input bit wr, input bit err, input logic [31:0] rd);
    if (err) return 32'h0;
    if (wr)  return 32'h0;
    return rd;
  endfunction

  // One APB transfer; the slave answers after dly extra BUS cycles. Ends in the cycle after RESP.
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int dly, input bit err, input bit ack,
                          input logic [31:0] exp_rd, input bit exp_err);
    logic [31:0] a8;
    a8 = {24'h0, addr[7:0]};
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    wb_dat_i = $urandom;
    chk("setup_pready", PREADY, 0);
    tick;
    PENABLE = 1'b1;
    for (int i = 0; i <= dly; i++) begin
      chk("bus_cyc", wb_cyc_o, 1);
      chk("bus_stb", wb_stb_o, 1);
      chk("bus_pready", PREADY, 0);
      chk("bus_we", wb_we_o, wr);
      chk("bus_adr", wb_adr_o, a8);
      chk("bus_dat", wb_dat_o, wdata);
      if (i == dly) begin
        wb_ack_i = ack; wb_err_i = err; wb_dat_i = rdata;
      end
      tick;
    end
    chk("resp_pready", PREADY, 1);
    chk("resp_prdata", PRDATA, exp_rd);
    chk("resp_pslverr", PSLVERR, exp_err);
    chk("resp_cyc", wb_cyc_o, 0);
    chk("resp_stb", wb_stb_o, 0);
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = $urandom;
    tick;
    chk("post_pready", PREADY, 0);
    chk("post_prdata", PRDATA, 0);
    chk("post_pslverr", PSLVERR, 0);
    chk("post_cyc", wb_cyc_o, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b0, 32'h0000_001C, 32'h0,          32'h0000_00A5, 0, 1'b0, 1'b1, 32'h0000_00A5, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 32'hFFFF_FFFF, 3, 1'b0, 1'b1, 32'h0,          1'b0};
    tbl[2] = '{1'b0, 32'h0000_0030, 32'h0,          32'hDEAD_BEEF, 0, 1'b1, 1'b1, 32'h0,          1'b1};
    tbl[3] = '{1'b0, 32'hFFFF_FF80, 32'h0,          32'h0000_5A5A, 1, 1'b0, 1'b1, 32'h0000_5A5A, 1'b0};
    tbl[4] = '{1'b1, 32'h0000_00F0, 32'hCAFE_F00D, 32'h1111_1111, 2, 1'b1, 1'b0, 32'h0,          1'b1};

    nRST = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; irq_i = 1'b0;
    tick; tick;
    chk("rst_pready", PREADY, 0);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_prdata", PRDATA, 0);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_int", INT, 0);
    nRST = 1'b1;
    tick;

    for (int i = 0; i < 5; i++) begin
      run_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].dly,
               tbl[i].err, tbl[i].ack, tbl[i].exp_rd, tbl[i].exp_err);
      tick;
    end

    // Back-to-back reads with PSEL held high.
    run_xfer(1'b0, 32'h10, 32'h0, 32'h0000_1111, 0, 1'b0, 1'b1, 32'h0000_1111, 1'b0);
    run_xfer(1'b0, 32'h14, 32'h0, 32'h0000_2222, 1, 1'b0, 1'b1, 32'h0000_2222, 1'b0);
    tick;

    // ack/err while idle must be ignored.
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h7777_7777;
    tick;
    chk("idle_ack_cyc", wb_cyc_o, 0);
    chk("idle_ack_pready", PREADY, 0);
    chk("idle_ack_pslverr", PSLVERR, 0);
    chk("idle_ack_prdata", PRDATA, 0);
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    tick;

    // PSEL dropped during BUS: cycle completes, no response phase.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h20;
    tick;
    PSEL = 1'b0; PENABLE = 1'b0;
    chk("drop_cyc0", wb_cyc_o, 1);
    tick;
    chk("drop_cyc1", wb_cyc_o, 1);
    wb_ack_i = 1'b1; wb_dat_i = 32'h3333_3333;
    tick;
    chk("drop_cyc_end", wb_cyc_o, 0);
    chk("drop_pready", PREADY, 0);
    chk("drop_prdata", PRDATA, 0);
    wb_ack_i = 1'b0;
    tick;
    chk("drop_pready2", PREADY, 0);
    run_xfer(1'b1, 32'h24, 32'hA5A5_5A5A, 32'h0, 0, 1'b0, 1'b1, 32'h0, 1'b0);
    tick;

`ifdef WB_TIMEOUT_EN
    // Never acked: aborted after TO cycles in BUS.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h40;
    tick;
    PENABLE = 1'b1;
    for (int i = 0; i < TO; i++) begin
      chk("to_cyc", wb_cyc_o, 1);
      chk("to_pready", PREADY, 0);
      tick;
    end
    chk("to_resp_pready", PREADY, 1);
    chk("to_resp_pslverr", PSLVERR, 1);
    chk("to_resp_prdata", PRDATA, 0);
    chk("to_resp_cyc", wb_cyc_o, 0);
    tick;
    chk("to_post_pready", PREADY, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick;
    run_xfer(1'b0, 32'h44, 32'h0, 32'h0000_BEEF, TO - 1, 1'b0, 1'b1, 32'h0000_BEEF, 1'b0);
    tick;
`else
    // Without the timeout the bridge waits as long as the slave needs.
    run_xfer(1'b0, 32'h44, 32'h0, 32'h0000_BEEF, 12, 1'b0, 1'b1, 32'h0000_BEEF, 1'b0);
    tick;
`endif

    // Reset in the middle of a BUS cycle.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h08; PWDATA = 32'h5555_AAAA;
    tick;
    PENABLE = 1'b1;
    chk("mid_cyc_before", wb_cyc_o, 1);
    #2;
    nRST = 1'b0;
    #1;
    chk("mid_rst_cyc", wb_cyc_o, 0);
    chk("mid_rst_stb", wb_stb_o, 0);
    chk("mid_rst_pready", PREADY, 0);
    chk("mid_rst_we", wb_we_o, 0);
    chk("mid_rst_dat", wb_dat_o, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    tick;
    nRST = 1'b1;
    tick;
    chk("after_rst_cyc", wb_cyc_o, 0);
    run_xfer(1'b0, 32'h1C, 32'h0, 32'h0000_00C3, 0, 1'b0, 1'b1, 32'h0000_00C3, 1'b0);

    // Interrupt synchroniser: two edges of latency, level follows input.
    irq_i = 1'b1;
    tick;
    chk("int_edge1", INT, 0);
    tick;
    chk("int_edge2", INT, 1);
    tick;
    chk("int_hold", INT, 1);
    irq_i = 1'b0;
    tick;
    chk("int_fall1", INT, 1);
    tick;
    chk("int_fall2", INT, 0);

    // Random transfers against the reference model.
    for (int n = 0; n < 40; n++) begin
      bit          wr, err, ack;
      int          mode, dly;
      logic [31:0] addr, wd, rd;
      wr   = bit'($urandom_range(0, 1));
      mode = $urandom_range(0, 5);
      err  = (mode < 2);
      ack  = (mode != 0);
      dly  = $urandom_range(0, 3);
      addr = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      run_xfer(wr, addr, wd, rd, dly, err, ack, model_rdata(wr, err, rd), err);
      if ($urandom_range(0, 1) == 1) tick;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
